fft_rom_streamer: RTL and testbench

- Drives the fft_rom test-signal pROM (1024 x 16, synchronous read, 1-cycle latency) and turns its output into a framed valid/ready sample stream for the FFT input stage.
- Generates ROM addresses and hides the ROM read latency behind a 2-entry skid buffer.
- Converts offset-binary samples to two's complement and marks first/last sample of each frame.

---
 rtl/fft_stream_pkg.sv | 27 ++
 rtl/fft_rom_streamer_if.sv | 14 +
 rtl/stream_skid_fifo.sv | 61 ++++++
 rtl/fft_rom_streamer.sv | 151 +++++++++++++++
 tb/tb_fft_rom_streamer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the fft_rom test-signal streamer.
// Holds the FSM state encoding, the skid-FIFO entry layout and the offset-removal helper.
package fft_stream_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] DC_OFFSET = 16'h0800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              last;
    } fifo_entry_t;

    // Offset-binary to two's complement: plain modular subtraction of the DC level.
    function automatic logic [DATA_W-1:0] remove_offset(input logic [DATA_W-1:0] word,
                                                        input logic [DATA_W-1:0] offset);
        return word - offset;
    endfunction

endpackage

// File: rtl/fft_rom_streamer_if.sv
// Framed valid/ready sample stream between the ROM streamer and the FFT input stage.
interface fft_rom_streamer_if;
    import fft_stream_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tsop;
    logic              tlast;

    modport master (output tdata, output tvalid, output tsop, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tsop, input tlast, output tready);

endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO of tagged samples; slot0 is always the head so outputs come straight from flops.
module stream_skid_fifo
    import fft_stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count,
    output logic        empty
);

    fifo_entry_t slot0_r;
    fifo_entry_t slot1_r;
    logic [1:0]  count_r;

    // Storage and occupancy; a push into a full FIFO without a pop is dropped rather than corrupting state.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= din;
                        count_r <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        slot1_r <= din;
                        count_r <= 2'd2;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        slot0_r <= slot1_r;
                        slot1_r <= din;
                    end else begin
                        slot0_r <= din;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head  = slot0_r;
    assign count = count_r;
    assign empty = (count_r == 2'd0);

endmodule

// File: rtl/fft_rom_streamer.sv
// Reads the fft_rom test-signal pROM and streams DC-corrected, frame-tagged samples.
// A 2-entry skid FIFO plus a one-read credit hides the ROM's one-cycle read latency.
module fft_rom_streamer
    import fft_stream_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 16,
    parameter int                FRAME_LEN = 1024,
    parameter logic [DATA_W-1:0] DC_OFFSET = 16'h0800
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    output logic [ADDR_W-1:0]  rom_ad,
    output logic               rom_ce,
    output logic               rom_oce,
    output logic               rom_reset,
    input  logic [DATA_W-1:0]  rom_dout,
    fft_rom_streamer_if.master m,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              cont_r;
    logic              stop_pend_r;
    logic              inflight_r;
    logic              cap_sop_r;
    logic              cap_last_r;
    logic              frame_done_r;

    fifo_entry_t       push_entry_s;
    fifo_entry_t       head_s;
    logic [1:0]        fifo_count_s;
    logic              fifo_empty_s;

    logic              pop_s;
    logic [2:0]        credit_used_s;
    logic              issue_s;
    logic              last_issue_s;
    logic              wrap_s;
    logic              start_s;

    // Credit: a slot freed by this cycle's pop is reusable now, which sustains one read per clock.
    always_comb begin
        pop_s         = !fifo_empty_s && m.tready;
        credit_used_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s       = (state_r == RUN) && (credit_used_s < 3'd2);
        last_issue_s  = issue_s && (rd_addr_r == LAST_ADDR);
        wrap_s        = last_issue_s && cont_r && !stop_pend_r && !stop;
        start_s       = (state_r == IDLE) && start;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_issue_s && !wrap_s) state_nxt_s = DRAIN;
                else                         state_nxt_s = RUN;
            end
            DRAIN: begin
                if (fifo_empty_s && !inflight_r) state_nxt_s = IDLE;
                else                             state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // Address counter, mode latches and read-tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_r    <= FIRST_ADDR;
            cont_r       <= 1'b0;
            stop_pend_r  <= 1'b0;
            inflight_r   <= 1'b0;
            cap_sop_r    <= 1'b0;
            cap_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            inflight_r   <= issue_s;
            cap_sop_r    <= issue_s && (rd_addr_r == FIRST_ADDR);
            cap_last_r   <= last_issue_s;
            frame_done_r <= pop_s && head_s.last;

            if (start_s)           rd_addr_r <= FIRST_ADDR;
            else if (last_issue_s) rd_addr_r <= FIRST_ADDR;
            else if (issue_s)      rd_addr_r <= rd_addr_r + ADDR_ONE;
            else                   rd_addr_r <= rd_addr_r;

            if (start_s)     cont_r <= continuous;
            else if (wrap_s) cont_r <= continuous;
            else             cont_r <= cont_r;

            // In IDLE only a stop that arrives together with start survives.
            if (state_r == IDLE)            stop_pend_r <= start && stop;
            else if (state_nxt_s == IDLE)   stop_pend_r <= 1'b0;
            else if (stop)                  stop_pend_r <= 1'b1;
            else                            stop_pend_r <= stop_pend_r;
        end
    end

    // Capture path: the ROM word arriving this cycle belongs to the read issued last cycle.
    always_comb begin
        push_entry_s.data = remove_offset(rom_dout, DC_OFFSET);
        push_entry_s.sop  = cap_sop_r;
        push_entry_s.last = cap_last_r;
    end

    stream_skid_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_r),
        .din   (push_entry_s),
        .pop   (pop_s),
        .head  (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign rom_ad     = rd_addr_r;
    assign rom_ce     = issue_s;
    assign rom_oce    = 1'b1;
    assign rom_reset  = reset;
    assign busy       = (state_r != IDLE);
    assign frame_done = frame_done_r;

    assign m.tvalid = !fifo_empty_s;
    assign m.tdata  = head_s.data;
    assign m.tsop   = head_s.sop;
    assign m.tlast  = head_s.last;

endmodule

// File: tb/tb_fft_rom_streamer.sv
// Bench for fft_rom_streamer: a 1024-sample instance driven by random backpressure and a
// 16-sample instance driven by a per-cycle vector table, both fed from a behavioural ROM.
module tb_fft_rom_streamer;

    localparam int NV = 62;

    logic clk;
    logic reset;

    logic        start_l, stop_l, cont_l;
    logic [9:0]  rom_ad_l;
    logic        rom_ce_l, rom_oce_l, rom_reset_l;
    logic [15:0] rom_dout_l;
    logic        busy_l, fd_l;

    logic        start_s, stop_s, cont_s;
    logic [9:0]  rom_ad_s;
    logic        rom_ce_s, rom_oce_s, rom_reset_s;
    logic [15:0] rom_dout_s;
    logic        busy_s, fd_s;

    fft_rom_streamer_if if_l ();
    fft_rom_streamer_if if_s ();

    fft_rom_streamer #(.ADDR_W(10), .DATA_W(16), .FRAME_LEN(1024), .DC_OFFSET(16'h0800)) dut_l (
        .clk(clk), .reset(reset), .start(start_l), .continuous(cont_l), .stop(stop_l),
        .rom_ad(rom_ad_l), .rom_ce(rom_ce_l), .rom_oce(rom_oce_l), .rom_reset(rom_reset_l),
        .rom_dout(rom_dout_l), .m(if_l), .busy(busy_l), .frame_done(fd_l)
    );

    fft_rom_streamer #(.ADDR_W(10), .DATA_W(16), .FRAME_LEN(16), .DC_OFFSET(16'h0800)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .continuous(cont_s), .stop(stop_s),
        .rom_ad(rom_ad_s), .rom_ce(rom_ce_s), .rom_oce(rom_oce_s), .rom_reset(rom_reset_s),
        .rom_dout(rom_dout_s), .m(if_s), .busy(busy_s), .frame_done(fd_s)
    );

    // Behavioural ROM contents and the two synchronous read ports.
    logic [15:0] rom_mem [1024];

    always @(posedge clk) if (rom_ce_l) rom_dout_l <= rom_mem[rom_ad_l];
    always @(posedge clk) if (rom_ce_s) rom_dout_s <= rom_mem[rom_ad_s];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard for the long instance: every handshake must be the next ROM sample of the frame.
    int          outst;
    int          exp_idx;
    bit          prev_stall;
    bit          hs_m;
    logic [17:0] held;
    logic [17:0] exp_w;
    logic [15:0] first4 [4];

    always @(negedge clk) begin
        if (reset) begin
            outst      = 0;
            exp_idx    = 0;
            prev_stall = 1'b0;
        end else begin
            hs_m = if_l.tvalid && if_l.tready;
            if (rom_ce_l) chk("credit", 32'((outst - int'(hs_m)) < 2), 32'd1);
            if (prev_stall)
                chk("stall_hold", {if_l.tvalid, if_l.tdata, if_l.tsop, if_l.tlast}, {1'b1, held});
            if (hs_m) begin
                exp_w = {rom_mem[exp_idx] - 16'h0800, exp_idx == 0, exp_idx == 1023};
                chk("sample", {if_l.tdata, if_l.tsop, if_l.tlast}, exp_w);
                if (exp_idx < 4) first4[exp_idx] = if_l.tdata;
                exp_idx = (exp_idx + 1) % 1024;
            end
            outst      = outst + int'(rom_ce_l) - int'(hs_m);
            prev_stall = if_l.tvalid && !if_l.tready;
            held       = {if_l.tdata, if_l.tsop, if_l.tlast};
        end
    end

    // Start a run on the long instance and follow it until busy falls again.
    task automatic run_stream(input bit c, input bit rnd, input int stop_at, input int budget,
                              output int n_hs, output int span, output int tail, output int n_fd);
        int first, last;
        bit seen, done;
        first = -1; last = -1; seen = 1'b0; done = 1'b0;
        n_hs = 0; n_fd = 0; span = 0; tail = 99;
        @(posedge clk); #1;
        start_l = 1'b1; cont_l = c; if_l.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_l.tvalid && if_l.tready) begin
                if (first < 0) first = i;
                last = i;
                n_hs++;
            end
            if (fd_l) n_fd++;
            if (busy_l) seen = 1'b1;
            else if (seen) begin
                done = 1'b1;
                tail = i - last;
            end
            if (done) break;
            @(posedge clk); #1;
            start_l     = 1'b0;
            stop_l      = (stop_at >= 0) && (n_hs == stop_at);
            if_l.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!done) chk("run_timeout", 32'd0, 32'd1);
        span = last - first + 1;
        start_l = 1'b0; stop_l = 1'b0; cont_l = 1'b0; if_l.tready = 1'b1;
    endtask

    task automatic check_first4(input string tag);
        logic [15:0] exp4 [4];
        exp4 = '{16'h0000, 16'h0515, 16'h0548, 16'h01BF};
        for (int i = 0; i < 4; i++) chk(tag, first4[i], exp4[i]);
    endtask

    typedef struct {
        logic        start, stop, cont;
        logic        valid;
        logic [15:0] data;
        logic        sop, last, busy, fd;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int n_hs, span, tail, n_fd, cnt, s, n, j;

        for (int i = 0; i < 1024; i++) rom_mem[i] = 16'($urandom);
        rom_mem[0]  = 16'h0800;
        rom_mem[1]  = 16'h0D15;
        rom_mem[2]  = 16'h0D48;
        rom_mem[3]  = 16'h09BF;
        rom_mem[15] = 16'h0A91;

        // Short-frame timeline: start at cycles 0 (single) and 23 (continuous, stopped at 44);
        // start at 8 lands in RUN and stop at 21 lands in IDLE, both must be ignored.
        // A run started in cycle s shows sample j in cycle s+3+j and is busy s+1 .. s+3+16n.
        for (int k = 0; k < NV; k++) begin
            vecs[k] = '{default: '0};
            vecs[k].start = (k == 0) || (k == 8) || (k == 23);
            vecs[k].stop  = (k == 21) || (k == 44);
            vecs[k].cont  = (k == 8) || (k >= 23);
            for (int seg = 0; seg < 2; seg++) begin
                s = (seg == 0) ? 0 : 23;
                n = (seg == 0) ? 1 : 2;
                if (k >= s + 1 && k <= s + 3 + 16 * n) vecs[k].busy = 1'b1;
                if (k >= s + 3 && k < s + 3 + 16 * n) begin
                    j = (k - s - 3) % 16;
                    vecs[k].valid = 1'b1;
                    vecs[k].data  = rom_mem[j] - 16'h0800;
                    vecs[k].sop   = (j == 0);
                    vecs[k].last  = (j == 15);
                end
                if (k > s + 3 && ((k - s - 3) % 16) == 0 && k <= s + 3 + 16 * n) vecs[k].fd = 1'b1;
            end
        end

        reset = 1'b1;
        start_l = 1'b0; stop_l = 1'b0; cont_l = 1'b0; if_l.tready = 1'b1;
        start_s = 1'b0; stop_s = 1'b0; cont_s = 1'b0; if_s.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rom_reset_hi", {rom_reset_l, rom_reset_s}, 2'b11);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_state_l", {rom_ad_l, rom_ce_l, if_l.tvalid, if_l.tsop, if_l.tlast, if_l.tdata, busy_l, fd_l}, 32'd0);
        chk("reset_state_s", {rom_ad_s, rom_ce_s, if_s.tvalid, if_s.tsop, if_s.tlast, if_s.tdata, busy_s, fd_s}, 32'd0);
        chk("rom_static", {rom_reset_l, rom_oce_l, rom_reset_s, rom_oce_s}, 4'b0101);

        // Short frame (FRAME_LEN=16), table driven.
        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            start_s = vecs[k].start; stop_s = vecs[k].stop; cont_s = vecs[k].cont;
            @(negedge clk);
            chk($sformatf("short_ctrl[%0d]", k), {if_s.tvalid, busy_s, fd_s},
                {vecs[k].valid, vecs[k].busy, vecs[k].fd});
            if (vecs[k].valid)
                chk($sformatf("short_data[%0d]", k), {if_s.tdata, if_s.tsop, if_s.tlast},
                    {vecs[k].data, vecs[k].sop, vecs[k].last});
        end
        start_s = 1'b0; stop_s = 1'b0; cont_s = 1'b0;

        // Single frame, ready held high.
        run_stream(1'b0, 1'b0, -1, 1200, n_hs, span, tail, n_fd);
        chk("single_count", n_hs, 32'd1024);
        chk("single_rate", span, 32'd1024);
        chk("single_done", n_fd, 32'd1);
        chk("single_busy_tail", 32'(tail <= 2), 32'd1);
        check_first4("single_first4");

        // Single frame under ~50% random backpressure.
        run_stream(1'b0, 1'b1, -1, 5000, n_hs, span, tail, n_fd);
        chk("bp_count", n_hs, 32'd1024);
        chk("bp_done", n_fd, 32'd1);
        check_first4("bp_first4");

        // Continuous frames, stop pulsed partway through frame 3.
        run_stream(1'b1, 1'b0, 2048 + 300, 3300, n_hs, span, tail, n_fd);
        chk("cont_count", n_hs, 32'd3072);
        chk("cont_no_bubble", span, 32'd3072);
        chk("cont_done", n_fd, 32'd3);

        // Reset at sample 100, then a fresh frame.
        @(posedge clk); #1;
        start_l = 1'b1; cont_l = 1'b0; if_l.tready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_l.tvalid && if_l.tready) cnt++;
            if (cnt == 100) break;
            @(posedge clk); #1;
            start_l = 1'b0;
        end
        chk("pre_reset_count", cnt, 32'd100);
        @(posedge clk); #1;
        start_l = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_state", {if_l.tvalid, busy_l, rom_ce_l}, 3'b000);
        run_stream(1'b0, 1'b0, -1, 1200, n_hs, span, tail, n_fd);
        chk("restart_count", n_hs, 32'd1024);
        chk("restart_done", n_fd, 32'd1);
        check_first4("restart_first4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
